// File: rtl/result_converter.sv
// result_converter
//   Back end of the sine/cosine path. Latches a CORDIC fixed-point sin/cos pair
//   of the reduced angle, undoes the quadrant fold given by flip, and converts
//   both values to IEEE 754 single precision for the processor.
//
//   Optional feature macro: RESULT_SATURATE_EN
//     defined     - after unfolding, |sin| and |cos| are clamped to 1.0
//                   (2^FRAC_BITS), absorbing CORDIC gain overshoot; sign kept.
//     not defined - values are converted as-is.
//
// Ports
//   clk       in   1     system clock, rising edge
//   rst_n     in   1     asynchronous active-low reset
//   valid_in  in   1     cordic result ready (level, held until recived)
//   sin_in    in   IN_W  signed fixed-point sine of reduced angle
//   cos_in    in   IN_W  signed fixed-point cosine of reduced angle
//   flip      in   3     signed quadrant count from the normalizer
//   start     in   1     processor begins next op; clears done
//   recived   out  1     one-cycle pulse: cordic result latched
//   sin_out   out  32    IEEE 754 sine of original angle
//   cos_out   out  32    IEEE 754 cosine of original angle
//   done      out  1     level: sin_out/cos_out valid
module result_converter #(
    parameter int IN_W      = 16,
    parameter int FRAC_BITS = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [IN_W-1:0] sin_in,
    input  logic [IN_W-1:0] cos_in,
    input  logic [2:0]      flip,
    input  logic            start,
    output logic            recived,
    output logic [31:0]     sin_out,
    output logic [31:0]     cos_out,
    output logic            done
);

    localparam int KW = $clog2(IN_W + 2);
`ifdef RESULT_SATURATE_EN
    localparam logic [IN_W:0] ONE = {{IN_W{1'b0}}, 1'b1} << FRAC_BITS;
`endif

    typedef enum logic [2:0] {IDLE, QUAD, NORM_S, NORM_C, DONE} state_t;

    state_t          state;
    logic [IN_W-1:0] s_lat;
    logic [IN_W-1:0] c_lat;
    logic [2:0]      flip_lat;

    // Shared normaliser: working magnitude, sign and shift count.
    logic [IN_W:0]   mag;
    logic            sgn;
    logic [KW-1:0]   k;

    // Cosine operand parked while sine is normalised.
    logic [IN_W:0]   c_mag_r;
    logic            c_sgn_r;

    logic signed [IN_W:0] s_ext, c_ext, s_rot, c_rot;
    logic [1:0]           q;
    logic [IN_W:0]        s_mag_q, c_mag_q;

    function automatic logic [IN_W:0] abs_val(input logic signed [IN_W:0] v);
        return v[IN_W] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Leading one sits at bit IN_W after k shifts, so the value is
    // 2^(IN_W-k-FRAC_BITS) * 1.frac; the bits below it are the mantissa.
    function automatic logic [31:0] pack(input logic s, input logic [IN_W-1:0] frac,
                                         input logic [KW-1:0] kk);
        logic [7:0]  e;
        logic [22:0] man;
        e   = 8'(127 + IN_W - FRAC_BITS - int'(kk));
        man = '0;
        man[22 -: IN_W] = frac;
        return {s, e, man};
    endfunction

    // Quadrant unfold at IN_W+1 bits so negating -2^(IN_W-1) cannot overflow.
    always_comb begin
        s_ext = {s_lat[IN_W-1], s_lat};
        c_ext = {c_lat[IN_W-1], c_lat};
        q     = 2'(3'd0 - flip_lat);
        s_rot = s_ext;
        c_rot = c_ext;
        case (q)
            2'd1: begin s_rot = c_ext;  c_rot = -s_ext; end
            2'd2: begin s_rot = -s_ext; c_rot = -c_ext; end
            2'd3: begin s_rot = -c_ext; c_rot = s_ext;  end
            default: begin s_rot = s_ext; c_rot = c_ext; end
        endcase
        s_mag_q = abs_val(s_rot);
        c_mag_q = abs_val(c_rot);
`ifdef RESULT_SATURATE_EN
        if (s_mag_q > ONE) s_mag_q = ONE;
        if (c_mag_q > ONE) c_mag_q = ONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            recived  <= 1'b0;
            done     <= 1'b0;
            sin_out  <= '0;
            cos_out  <= '0;
            s_lat    <= '0;
            c_lat    <= '0;
            flip_lat <= '0;
            mag      <= '0;
            sgn      <= 1'b0;
            k        <= '0;
            c_mag_r  <= '0;
            c_sgn_r  <= 1'b0;
        end else begin
            recived <= 1'b0;
            if (start) done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        s_lat    <= sin_in;
                        c_lat    <= cos_in;
                        flip_lat <= flip;
                        recived  <= 1'b1;
                        state    <= QUAD;
                    end
                end
                QUAD: begin
                    mag     <= s_mag_q;
                    sgn     <= s_rot[IN_W];
                    k       <= '0;
                    c_mag_r <= c_mag_q;
                    c_sgn_r <= c_rot[IN_W];
                    state   <= NORM_S;
                end
                NORM_S: begin
                    if (mag == '0 || mag[IN_W]) begin
                        sin_out <= (mag == '0) ? 32'h0 : pack(sgn, mag[IN_W-1:0], k);
                        mag     <= c_mag_r;
                        sgn     <= c_sgn_r;
                        k       <= '0;
                        state   <= NORM_C;
                    end else begin
                        mag <= mag << 1;
                        k   <= k + KW'(1);
                    end
                end
                NORM_C: begin
                    if (mag == '0 || mag[IN_W]) begin
                        cos_out <= (mag == '0) ? 32'h0 : pack(sgn, mag[IN_W-1:0], k);
                        state   <= DONE;
                    end else begin
                        mag <= mag << 1;
                        k   <= k + KW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_converter.sv
module tb_result_converter;

    localparam int IN_W      = 16;
    localparam int FRAC_BITS = 14;
    localparam int MAX_LAT   = 2 * (IN_W + 2) + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] sin_in = '0;
    logic [15:0] cos_in = '0;
    logic [2:0]  flip = '0;
    logic        recived;
    logic        done;
    logic [31:0] sin_out;
    logic [31:0] cos_out;

    int checks = 0;
    int failures = 0;
    int rcv_cnt = 0;
    logic [31:0] exp_sin = '0;
    logic [31:0] exp_cos = '0;
    logic        exp_valid = 1'b0;

    logic [15:0] specials [7] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001,
                                  16'hFFFF, 16'h4000, 16'hC000};

    always #5 clk = ~clk;

    result_converter #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sin_in(sin_in),
        .cos_in(cos_in), .flip(flip), .start(start), .recived(recived),
        .sin_out(sin_out), .cos_out(cos_out), .done(done)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Real-number view: value = v / 2^FRAC_BITS, written as 1.m * 2^(p-FRAC_BITS).
    function automatic logic [31:0] to_float(input int v);
        int m, p, e, man;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i <= IN_W; i++) if (m >= (1 << i)) p = i;
        e   = 127 + p - FRAC_BITS;
        man = (m - (1 << p)) << (23 - p);
        return {(v < 0), e[7:0], man[22:0]};
    endfunction

    task automatic model(input logic [15:0] s, input logic [15:0] c, input logic [2:0] f,
                         output logic [31:0] so, output logic [31:0] co);
        int sv, cv, fv, q, rs, rc;
        sv = int'($signed(s));
        cv = int'($signed(c));
        fv = int'($signed(f));
        q  = ((-fv) % 4 + 4) % 4;
        case (q)
            0: begin rs = sv;  rc = cv;  end
            1: begin rs = cv;  rc = -sv; end
            2: begin rs = -sv; rc = -cv; end
            default: begin rs = -cv; rc = sv; end
        endcase
`ifdef RESULT_SATURATE_EN
        if (rs >  (1 << FRAC_BITS)) rs =  (1 << FRAC_BITS);
        if (rs < -(1 << FRAC_BITS)) rs = -(1 << FRAC_BITS);
        if (rc >  (1 << FRAC_BITS)) rc =  (1 << FRAC_BITS);
        if (rc < -(1 << FRAC_BITS)) rc = -(1 << FRAC_BITS);
`endif
        so = to_float(rs);
        co = to_float(rc);
    endtask

    // Continuous comparison whenever the DUT claims a valid result.
    always @(negedge clk) begin
        if (recived) rcv_cnt++;
        if (rst_n && done && exp_valid) begin
            check32("cmp_sin", sin_out, exp_sin);
            check32("cmp_cos", cos_out, exp_cos);
        end
    end

    task automatic do_op(input logic [15:0] s, input logic [15:0] c, input logic [2:0] f,
                         input bit with_start, input bit hold_valid,
                         input bit has_lit, input logic [31:0] lit_s, input logic [31:0] lit_c);
        logic [31:0] ms, mc;
        int n, rc0;
        bit got;
        model(s, c, f, ms, mc);
        @(negedge clk);
        sin_in = s; cos_in = c; flip = f; valid_in = 1'b1; start = with_start;
        rc0 = rcv_cnt;
        got = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (recived) begin got = 1; break; end
        end
        check32("recived_seen", {31'b0, got}, 32'd1);
        if (with_start) check32("start_valid_clear", {31'b0, done}, 32'd0);
        exp_sin = ms; exp_cos = mc; exp_valid = 1'b1;
        if (!hold_valid) valid_in = 1'b0;
        n = 0; got = 0;
        while (n < MAX_LAT + 5) begin
            @(negedge clk);
            n++;
            if (n == 3) valid_in = 1'b0;
            if (done) begin got = 1; break; end
        end
        check32("done_seen", {31'b0, got}, 32'd1);
        check32("latency_ok", {31'b0, (n <= MAX_LAT)}, 32'd1);
        check32("sin_model", sin_out, ms);
        check32("cos_model", cos_out, mc);
        if (has_lit) begin
            check32("sin_lit", sin_out, lit_s);
            check32("cos_lit", cos_out, lit_c);
        end
        repeat (2) @(negedge clk);
        check32("done_hold", {31'b0, done}, 32'd1);
        check32("recived_pulses", 32'(rcv_cnt - rc0), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check32("start_clears", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int rc0, stale;
        bit got, ws;
        logic [15:0] rs, rcv;

        repeat (3) @(negedge clk);
        check32("rst_sin", sin_out, 32'h0);
        check32("rst_cos", cos_out, 32'h0);
        check32("rst_done", {31'b0, done}, 32'd0);
        check32("rst_recived", {31'b0, recived}, 32'd0);
        rst_n = 1'b1;

        do_op(16'h2000, 16'h376D, 3'd0, 0, 0, 1, 32'h3F000000, 32'h3F5DB400);
        pulse_start();
        do_op(16'h2000, 16'h376D, 3'b111, 0, 0, 1, 32'h3F5DB400, 32'hBF000000);
        pulse_start();
        do_op(16'h2000, 16'h376D, 3'd2, 0, 0, 1, 32'hBF000000, 32'hBF5DB400);
        pulse_start();
        do_op(16'h0000, 16'h4000, 3'd0, 0, 0, 1, 32'h00000000, 32'h3F800000);
        pulse_start();
`ifdef RESULT_SATURATE_EN
        do_op(16'h8000, 16'h4005, 3'd0, 0, 0, 1, 32'hBF800000, 32'h3F800000);
`else
        do_op(16'h8000, 16'h4005, 3'd0, 0, 0, 1, 32'hC0000000, 32'h3F800A00);
`endif
        pulse_start();
        // valid_in held through the busy states must not be acked again
        do_op(16'h0001, 16'h0003, 3'd3, 0, 1, 0, '0, '0);
        // start and valid_in together while done is still high
        do_op(16'hFFFF, 16'h8000, 3'b110, 1, 0, 0, '0, '0);
        pulse_start();

        // reset while normalising the sine
        @(negedge clk);
        sin_in = 16'h2000; cos_in = 16'h376D; flip = 3'd0; valid_in = 1'b1;
        got = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (recived) begin got = 1; break; end
        end
        check32("rst_op_recived", {31'b0, got}, 32'd1);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_valid = 1'b0;
        #1;
        check32("midrst_sin", sin_out, 32'h0);
        check32("midrst_cos", cos_out, 32'h0);
        check32("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rc0 = rcv_cnt;
        stale = 0;
        for (int i = 0; i < MAX_LAT + 5; i++) begin
            @(negedge clk);
            if (done) stale++;
        end
        check32("no_stale_done", 32'(stale), 32'd0);
        check32("no_stale_recived", 32'(rcv_cnt - rc0), 32'd0);
        do_op(16'h2000, 16'h376D, 3'b111, 0, 0, 1, 32'h3F5DB400, 32'hBF000000);

        for (int it = 0; it < 150; it++) begin
            rs  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 6)] : 16'($urandom);
            rcv = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 6)] : 16'($urandom);
            ws  = 1'($urandom_range(0, 1));
            if (!ws) pulse_start();
            do_op(rs, rcv, 3'($urandom), ws, 0, 0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
